// File: rtl/sync_evt_arbiter_pkg.sv
// Shared types and limits for the async event arbiter.
package sync_evt_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  localparam int N_REQ_MIN = 2;
  localparam int N_REQ_MAX = 16;
  localparam int N_REQ_DEF = 4;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/sync_evt_arbiter_sync2t.sv
// Two-flop synchroniser with an extra history flop for rising-edge detection.
module sync_evt_arbiter_sync2t (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic pulse
);

  logic [2:0] stage_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stage_q <= '0;
    else       stage_q <= {stage_q[1:0], din};
  end

  // stage_q[0] may be metastable; only stage_q[1] onward is trusted.
  assign pulse = stage_q[1] & ~stage_q[2];

endmodule

// File: rtl/sync_evt_arbiter.sv
// Synchronises N async event lines, holds them pending and offers them round-robin
// to one consumer over valid/ready; lost events are counted per channel.
//
//  state | meaning
//  IDLE  | no offer outstanding; registers the next round-robin pick if any pending
//  OFFER | evt_valid_o high, evt_id_o frozen until the consumer handshakes
module sync_evt_arbiter
  import sync_evt_arbiter_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_async_i,
  input  logic [N_REQ-1:0]       en_i,
  output logic                   evt_valid_o,
  output logic [IDW-1:0]         evt_id_o,
  input  logic                   evt_ready_i,
  output logic [N_REQ-1:0]       pend_o,
  output logic [N_REQ*CNT_W-1:0] drop_cnt_o,
  input  logic                   clr_drop_i
);

  arb_state_t       state_q;
  logic [IDW-1:0]   last_q;
  logic [N_REQ-1:0] pulse;
  logic [N_REQ-1:0] pend_q;
  logic [N_REQ-1:0] avail;

  assign avail  = pend_q & en_i;
  assign pend_o = pend_q;

  // First set bit strictly after 'last', wrapping; the doubled mask avoids a modulo per bit.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                             input logic [IDW-1:0]   last);
    logic [2*N_REQ-1:0] dbl;
    logic [IDW-1:0]     res;
    logic               found;
    dbl   = {mask, mask};
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && dbl[int'(last) + k]) begin
        res   = IDW'((int'(last) + k) % N_REQ);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_ch
    logic             offered;
    logic             hs;
    logic             pend_r;
    logic [CNT_W-1:0] cnt_r;

    sync_evt_arbiter_sync2t u_sync (
      .clk   (clk),
      .rstn  (rstn),
      .din   (req_async_i[i]),
      .pulse (pulse[i])
    );

    assign offered = evt_valid_o && (evt_id_o == IDW'(i));
    assign hs      = offered && evt_ready_i;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        pend_r <= 1'b0;
      end else if (!en_i[i]) begin
        // A disabled channel keeps only an offer already made to the consumer.
        pend_r <= offered && !hs && pend_r;
      end else if (hs) begin
        pend_r <= pulse[i];
      end else if (pulse[i]) begin
        pend_r <= 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_r <= '0;
      end else if (clr_drop_i) begin
        cnt_r <= '0;
      end else if (en_i[i] && pulse[i] && pend_r && !hs && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end

    assign pend_q[i]                     = pend_r;
    assign drop_cnt_o[i*CNT_W +: CNT_W] = cnt_r;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      last_q      <= IDW'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|avail) begin
            evt_id_o    <= rr_pick(avail, last_q);
            evt_valid_o <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready_i) begin
            last_q      <= evt_id_o;
            evt_valid_o <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          evt_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_evt_arbiter.sv
// Scoreboard bench for sync_evt_arbiter: expected ids queued at stimulus, popped at handshake.
module tb_sync_evt_arbiter;

  localparam int N     = 4;
  localparam int CW    = 8;
  localparam int IDW_T = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    en = '1;
  logic            evt_valid;
  logic [IDW_T-1:0] evt_id;
  logic            evt_ready = 1'b0;
  logic [N-1:0]    pend;
  logic [N*CW-1:0] drop_cnt;
  logic            clr_drop = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int sb[$];

  sync_evt_arbiter dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_async_i (req),
    .en_i        (en),
    .evt_valid_o (evt_valid),
    .evt_id_o    (evt_id),
    .evt_ready_i (evt_ready),
    .pend_o      (pend),
    .drop_cnt_o  (drop_cnt),
    .clr_drop_i  (clr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sb.delete();
    req = '0; en = '1; evt_ready = 1'b0; clr_drop = 1'b0;
    ticks(2);
    rstn = 1'b1;
    tick();
  endtask

  task automatic pulse_ch(input logic [N-1:0] m);
    req = req | m;
    ticks(3);
    req = req & ~m;
    ticks(3);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!evt_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, (n < 20), 1);
  endtask

  function automatic logic [CW-1:0] dc(input int i);
    return drop_cnt[i*CW +: CW];
  endfunction

  // Handshake monitor: valid & ready seen between edges means the next edge completes it.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rstn && evt_valid && evt_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(evt_id), 32'hFFFF);
        else                chk("sb_id", 32'(evt_id), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    rstn = 1'b0;
    ticks(2);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_pend", pend, 0);
    chk("rst_drop", drop_cnt, 0);
    rstn = 1'b1;
    tick();

    // 1: single rise on ch2, four-edge latency
    sb.push_back(2);
    req = 4'b0100;
    ticks(2);
    chk("t1_pend_early", pend, 0);
    tick();
    chk("t1_pend", pend, 4'b0100);
    chk("t1_valid_early", evt_valid, 0);
    tick();
    chk("t1_valid", evt_valid, 1);
    chk("t1_id", evt_id, 2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("t1_pend_clr", pend, 0);
    chk("t1_valid_clr", evt_valid, 0);
    req = '0;
    ticks(3);

    // 2: all four at once, ready held high -> 0,1,2,3 on alternate cycles
    do_reset();
    evt_ready = 1'b1;
    for (int i = 0; i < N; i++) sb.push_back(i);
    req = 4'b1111;
    ticks(3);
    chk("t2_valid_early", evt_valid, 0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("t2_valid", evt_valid, (j % 2 == 0));
      if (j % 2 == 0) chk("t2_id", evt_id, j / 2);
    end
    tick();
    chk("t2_idle", evt_valid, 0);
    chk("t2_pend", pend, 0);
    evt_ready = 1'b0;
    req = '0;

    // 3: drops while pending, saturation, clear
    do_reset();
    sb.push_back(1);
    for (int k = 0; k < 3; k++) pulse_ch(4'b0010);
    chk("t3_pend", pend, 4'b0010);
    chk("t3_drop2", dc(1), 2);
    chk("t3_drop_other", dc(0), 0);
    chk("t3_offer_id", evt_id, 1);
    for (int k = 0; k < 300; k++) pulse_ch(4'b0010);
    chk("t3_sat", dc(1), 255);
    clr_drop = 1'b1;
    tick();
    clr_drop = 1'b0;
    chk("t3_clr", dc(1), 0);
    chk("t3_pend_kept", pend, 4'b0010);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("t3_drain", pend, 0);

    // 4: enable dropped during an offer does not retract it
    do_reset();
    sb.push_back(3);
    pulse_ch(4'b1000);
    chk("t4_valid", evt_valid, 1);
    en = 4'b0111;
    ticks(4);
    chk("t4_hold_valid", evt_valid, 1);
    chk("t4_hold_id", evt_id, 3);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("t4_pend_clr", pend, 0);
    pulse_ch(4'b1000);
    pulse_ch(4'b1000);
    chk("t4_ignored_pend", pend, 0);
    chk("t4_ignored_valid", evt_valid, 0);
    chk("t4_drop", dc(3), 0);
    en = '1;

    // 5: pulse coincident with handshake keeps channel pending
    do_reset();
    sb.push_back(1);
    sb.push_back(1);
    pulse_ch(4'b0010);
    chk("t5_offer", evt_valid, 1);
    req[1] = 1'b1;
    ticks(2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    req[1] = 1'b0;
    chk("t5_pend_kept", pend, 4'b0010);
    chk("t5_bubble", evt_valid, 0);
    chk("t5_drop", dc(1), 0);
    tick();
    chk("t5_reoffer", evt_valid, 1);
    chk("t5_reoffer_id", evt_id, 1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("t5_drain", pend, 0);

    // 6: reset mid-offer with everything pending
    do_reset();
    sb.push_back(0);
    sb.push_back(1);
    req = 4'b1111;
    wait_valid("t6_wait0");
    chk("t6_first", evt_id, 0);
    chk("t6_pend_all", pend, 4'b1111);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    tick();
    req[0] = 1'b0;
    ticks(3);
    req[0] = 1'b1;
    ticks(3);
    chk("t6_pre_pend", pend, 4'b1111);
    chk("t6_pre_id", evt_id, 1);
    rstn = 1'b0;
    sb.delete();
    #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_id", evt_id, 0);
    chk("t6_rst_pend", pend, 0);
    ticks(2);
    rstn = 1'b1;
    for (int i = 0; i < N; i++) sb.push_back(i);
    wait_valid("t6_wait1");
    chk("t6_after_id", evt_id, 0);
    evt_ready = 1'b1;
    begin
      int n;
      n = 0;
      while ((pend != 0 || evt_valid) && n < 20) begin
        tick();
        n++;
      end
      chk("t6_drain_timeout", (n < 20), 1);
    end
    evt_ready = 1'b0;
    req = '0;
    ticks(2);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
